mips_dmem_responder: RTL and testbench
======================================

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  1  initiator request; held high with fields stable until ready seen.
REQ-006 Port we  input  1  1 = store, 0 = load.
REQ-007 Port addr  input  32  byte address.
REQ-008 Port wdata  input  32  store data.
REQ-009 Port rdata  output  32  load data, valid only while ready=1 and err=0.
REQ-010 Port ready  output  1  one-cycle response strobe, registered.
REQ-011 Port err  output  1  error flag, valid only while ready=1.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1 at a rising edge (accept edge E0), the block SHALL latch we/addr/wdata and go to WAIT, or directly to RESP when WAIT_CYCLES=0.
REQ-015 In WAIT, a 4-bit down-counter loaded with WAIT_CYCLES at E0 SHALL decrement each edge; at the edge where it reaches 0 the state SHALL go to RESP.
REQ-016 ready SHALL be high for exactly the one cycle following edge E0+WAIT_CYCLES, i.e. while in RESP.
REQ-017 RESP SHALL return to IDLE unconditionally at the next edge; req is ignored in WAIT and RESP.
REQ-018 A req still high in IDLE after RESP SHALL be accepted as a new request; minimum spacing between accept edges is WAIT_CYCLES+2 edges.
REQ-019 Word index SHALL be the latched addr[log2(DEPTH)+1:2]; address bits above that range SHALL be nonzero → out-of-range.
REQ-020 err SHALL be 1 in RESP when latched addr[1:0]!=0 or address out-of-range; in that case no storage write occurs and rdata SHALL be 0.
REQ-021 A valid store SHALL commit to storage on the edge entering RESP; rdata SHALL be 0 during a store response.
REQ-022 A valid load SHALL register storage[index] into rdata on the edge entering RESP; a load after a store to the same index SHALL return the stored value.
REQ-023 rdata and err SHALL return to 0 on the edge leaving RESP.
REQ-024 Latched request fields SHALL be used; changes to addr/wdata/we after E0 SHALL have no effect.

Reset
REQ-025 On reset low, state SHALL become IDLE, counter 0, ready 0, err 0, busy 0, rdata 0, immediately and asynchronously.
REQ-026 Storage contents SHALL NOT be reset; reads of never-written words are undefined.
REQ-027 Reset asserted during WAIT or RESP SHALL abort the transaction; a store not yet committed SHALL NOT be committed, and no ready pulse SHALL follow.
REQ-028 After reset release, the first rising edge with req=1 SHALL be a valid accept edge.

Configuration
REQ-029 Macro DMEM_BYTE_EN_EN: when defined, an input port be (4 bits) SHALL exist, be latched at E0, and a store SHALL update only bytes whose be bit is 1 (be[0] = bits 7:0); be=0 on a store SHALL complete with ready, no write, err=0.
REQ-030 When DMEM_BYTE_EN_EN is not defined, port be SHALL not exist and every valid store SHALL write the full word.

Verification
REQ-031 WAIT_CYCLES=2: store addr=0x10 wdata=0xDEADBEEF accepted at E0 → ready=1, err=0 exactly in cycle after E0+2; then load addr=0x10 → rdata=0xDEADBEEF with ready.
REQ-032 Misaligned load addr=0x13 and out-of-range load addr=0x400 (DEPTH=64) → ready=1, err=1, rdata=0; prior contents of word 4 unchanged.
REQ-033 req held high continuously for three loads → accept edges spaced exactly WAIT_CYCLES+2 edges apart, three ready pulses, busy low one cycle between each.
REQ-034 Store 0x12345678 to addr=0x20, reset pulsed low in WAIT before commit → no ready pulse; subsequent load of 0x20 returns previous value (e.g. 0x0 written earlier).
REQ-035 WAIT_CYCLES=0: load accepted at E0 → ready in cycle immediately after E0.
REQ-036 DMEM_BYTE_EN_EN defined: word 0x0 = 0xAABBCCDD, store wdata=0x11223344 be=4'b0101 → subsequent load returns 0xAA22CC44.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory responder with a fixed number of wait states per request.
// Define DMEM_BYTE_EN_EN to add the 4-bit byte-enable input for partial-word stores.
module mips_dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             accept, enter_resp;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic             cur_we;
  logic [31:0]      cur_addr, cur_wdata;
  logic [3:0]       cur_be;
  logic [IDX_W-1:0] idx;
  logic             bad, do_write;
  logic [31:0]      mem [DEPTH];

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] be_q;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
            cnt_next   = 4'd0;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
          cnt_next   = 4'd0;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the response is formed on the accept edge itself,
  // so the live request fields are used while still in IDLE.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

`ifdef DMEM_BYTE_EN_EN
  assign cur_be = (state == IDLE) ? be : be_q;
`else
  assign cur_be = 4'hF;
`endif

  assign idx      = cur_addr[IDX_W+1:2];
  assign bad      = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (IDX_W + 2)) != 32'd0);
  assign do_write = enter_resp && cur_we && !bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= 4'd0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
`ifdef DMEM_BYTE_EN_EN
        be_q    <= be;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      err   <= bad;
      rdata <= (!bad && !cur_we) ? mem[idx] : 32'd0;
    end else begin
      err   <= 1'b0;
      rdata <= 32'd0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: a 2-wait-state instance and a 0-wait-state instance.
// Byte-enable stores are exercised when DMEM_BYTE_EN_EN is defined.
module tb_mips_dmem_responder;

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_a, req_z;
  logic        we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_z;
  logic        ready_a, ready_z, err_a, err_z, busy_a, busy_z;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be;
`endif

  int tests = 0;
  int fails = 0;

  mips_dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_EN_EN
    .be(be),
`endif
    .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  mips_dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_EN_EN
    .be(be),
`endif
    .rdata(rdata_z), .ready(ready_z), .err(err_z), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? ready_z : ready_a;
  endfunction

  // One complete transaction; request fields are scrambled right after the
  // accept edge so only the latched copy can produce the right answer.
  task automatic apply_stimulus(input bit sel, input bit st, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input bit exp_err, input logic [31:0] exp_rd,
                                input string name);
    int n;
    int wc;
    wc = sel ? 0 : 2;
    @(negedge clk);
    we    = st;
    addr  = a;
    wdata = d;
`ifdef DMEM_BYTE_EN_EN
    be    = b;
`else
    if (b != 4'hF) $display("[TB] note: byte enables ignored in this build");
`endif
    if (sel) req_z = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    we    = ~st;
    addr  = 32'hFFFF_FFFF;
    wdata = ~d;
`ifdef DMEM_BYTE_EN_EN
    be    = ~b;
`endif
    check_output({name, " busy"}, {31'd0, sel ? busy_z : busy_a}, 32'd1);
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_a = 1'b0;
    req_z = 1'b0;
    check_output({name, " latency"}, 32'(n), 32'(wc));
    check_output({name, " err"}, {31'd0, sel ? err_z : err_a}, {31'd0, exp_err});
    check_output({name, " rdata"}, sel ? rdata_z : rdata_a, exp_rd);
    @(posedge clk); #1;
    check_output({name, " after"}, sel ? {29'd0, ready_z, err_z, busy_z} : {29'd0, ready_a, err_a, busy_a}, 32'd0);
    check_output({name, " rdata clr"}, sel ? rdata_z : rdata_a, 32'd0);
  endtask

  vec_t vecs [15];

  initial begin
    int n, pulses, low_busy, n_ready;
    int ready_at [3];

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h8000_0010, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFE_F00D};
    vecs[13] = '{1'b1, 32'h0000_0004, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 1'b0, 32'h1357_9BDF};

    reset = 1'b0;
    req_a = 1'b0;
    req_z = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
`ifdef DMEM_BYTE_EN_EN
    be    = 4'hF;
`endif
    #1;
    check_output("reset flags", {29'd0, ready_a, err_a, busy_a}, 32'd0);
    check_output("reset rdata", rdata_a, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      apply_stimulus(1'b0, vecs[i].st, vecs[i].a, vecs[i].d, vecs[i].b,
                     vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // req held high across three loads: accepts every WAIT_CYCLES+2 edges
    @(negedge clk);
    we    = 1'b0;
    addr  = 32'h10;
    req_a = 1'b1;
    n = 0; pulses = 0; low_busy = 0;
    while (pulses < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready_a) begin
        ready_at[pulses] = n;
        pulses++;
        check_output("b2b rdata", rdata_a, 32'hDEAD_BEEF);
      end else if (!busy_a && pulses > 0) begin
        low_busy++;
      end
    end
    req_a = 1'b0;
    check_output("b2b pulses", 32'(pulses), 32'd3);
    check_output("b2b first", 32'(ready_at[0]), 32'd3);
    check_output("b2b gap1", 32'(ready_at[1] - ready_at[0]), 32'd4);
    check_output("b2b gap2", 32'(ready_at[2] - ready_at[1]), 32'd4);
    check_output("b2b idle", 32'(low_busy), 32'd2);
    repeat (2) @(posedge clk);

    // store aborted by reset while waiting
    @(negedge clk);
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'h1234_5678;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    check_output("abort busy", {31'd0, busy_a}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_output("abort flags", {29'd0, ready_a, err_a, busy_a}, 32'd0);
    check_output("abort rdata", rdata_a, 32'd0);
    #2 reset = 1'b1;
    n_ready = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_a) n_ready++;
    end
    check_output("abort no ready", 32'(n_ready), 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0, 32'h0, "abort reload");

    // zero wait states
    apply_stimulus(1'b1, 1'b1, 32'h08, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0, "w0 store");
    apply_stimulus(1'b1, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 32'h55AA_55AA, "w0 load");
    apply_stimulus(1'b1, 1'b0, 32'h0A, 32'h0, 4'hF, 1'b1, 32'h0, "w0 misalign");

`ifdef DMEM_BYTE_EN_EN
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0, "be full");
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'b0101, 1'b0, 32'h0, "be partial");
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'hAA22_CC44, "be load");
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, "be none");
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'hAA22_CC44, "be reload");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
